// File: rtl/clk_rate_checker_if.sv
// rtl/clk_rate_checker_if.sv - measurement, limit and status signals of the clock-rate checker
interface clk_rate_checker_if;
  logic [31:0] value_in;
  logic [31:0] lo_limit;
  logic [31:0] hi_limit;
  logic        clear_alarm;
  logic [2:0]  state;
  logic        rate_ok;
  logic        alarm_sticky;
  logic        sample_valid;
  logic [31:0] sample_value;
  logic [15:0] fault_count;

  modport master (
    output value_in, lo_limit, hi_limit, clear_alarm,
    input  state, rate_ok, alarm_sticky, sample_valid, sample_value, fault_count
  );

  modport slave (
    input  value_in, lo_limit, hi_limit, clear_alarm,
    output state, rate_ok, alarm_sticky, sample_valid, sample_value, fault_count
  );
endinterface

// File: rtl/clk_rate_checker.sv
// rtl/clk_rate_checker.sv - periodic classifier of a clock-rate word with debounced health state
module clk_rate_checker #(
  parameter logic [23:0] SAMPLE_PERIOD = 24'd8388609,
  parameter int unsigned CONFIRM_N     = 3,
  parameter logic [31:0] STOP_LIMIT    = 32'd16
) (
  input  logic              clk100,
  input  logic              reset_in,
  clk_rate_checker_if.slave bus
);
  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_OK      = 3'd1,
    ST_LOW     = 3'd2,
    ST_HIGH    = 3'd3,
    ST_STOPPED = 3'd4
  } state_t;

  localparam logic [31:0] NO_MEAS = 32'hFFFFFFFF;
  localparam logic [23:0] LAST    = SAMPLE_PERIOD - 24'd1;
  localparam logic [3:0]  CONFIRM = 4'(CONFIRM_N);

  logic [23:0] period_cnt;
  state_t      cur_state;
  state_t      cand;
  state_t      cls;
  logic        cls_valid;
  logic [3:0]  conf_cnt;
  logic [3:0]  next_cnt;
  logic        capture;
  logic        switch_now;
  logic        fault_entry;
  logic        rate_ok_q;
  logic        alarm_q;
  logic        sample_valid_q;
  logic [31:0] sample_value_q;
  logic [15:0] fault_cnt_q;

  // Priority order matters when lo_limit > hi_limit: LOW is tested before HIGH.
  always_comb begin
    cls_valid = 1'b1;
    cls       = ST_OK;
    if (bus.value_in == NO_MEAS) begin
      cls_valid = 1'b0;
      cls       = ST_INIT;
    end else if (bus.value_in < STOP_LIMIT) begin
      cls = ST_STOPPED;
    end else if (bus.value_in < bus.lo_limit) begin
      cls = ST_LOW;
    end else if (bus.value_in > bus.hi_limit) begin
      cls = ST_HIGH;
    end
  end

  // cand==ST_INIT doubles as "no candidate" since no class ever maps to INIT.
  always_comb begin
    capture     = (period_cnt == LAST);
    next_cnt    = (cls == cand) ? conf_cnt + 4'd1 : 4'd1;
    switch_now  = capture && cls_valid && (cls != cur_state) && (next_cnt >= CONFIRM);
    fault_entry = switch_now && (cls != ST_OK);
  end

  always_ff @(posedge clk100) begin
    if (reset_in) begin
      period_cnt     <= 24'd0;
      cur_state      <= ST_INIT;
      cand           <= ST_INIT;
      conf_cnt       <= 4'd0;
      rate_ok_q      <= 1'b0;
      alarm_q        <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_value_q <= NO_MEAS;
      fault_cnt_q    <= 16'd0;
    end else begin
      sample_valid_q <= capture;
      if (capture) begin
        period_cnt     <= 24'd0;
        sample_value_q <= bus.value_in;
        if (!cls_valid) begin
          cur_state <= ST_INIT;
          rate_ok_q <= 1'b0;
          cand      <= ST_INIT;
          conf_cnt  <= 4'd0;
        end else if (cls == cur_state || switch_now) begin
          cand     <= ST_INIT;
          conf_cnt <= 4'd0;
          if (switch_now) begin
            cur_state <= cls;
            rate_ok_q <= (cls == ST_OK);
          end
        end else begin
          cand     <= cls;
          conf_cnt <= next_cnt;
        end
      end else begin
        period_cnt <= period_cnt + 24'd1;
      end

      if (fault_entry) begin
        alarm_q <= 1'b1;
        if (fault_cnt_q != 16'hFFFF) fault_cnt_q <= fault_cnt_q + 16'd1;
      end else if (bus.clear_alarm) begin
        alarm_q <= 1'b0;
      end
    end
  end

  assign bus.state        = cur_state;
  assign bus.rate_ok      = rate_ok_q;
  assign bus.alarm_sticky = alarm_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.sample_value = sample_value_q;
  assign bus.fault_count  = fault_cnt_q;
endmodule

// File: tb/tb_clk_rate_checker.sv
// tb/tb_clk_rate_checker.sv - directed bench for clk_rate_checker
`timescale 1ns/100ps
module tb_clk_rate_checker;
  logic clk100 = 1'b0;
  logic clk_fast = 1'b0;
  logic reset_in;
  logic reset_fast;
  int   checks = 0;
  int   failures = 0;

  always #5 clk100 = ~clk100;
  always #2 clk_fast = ~clk_fast;

  clk_rate_checker_if bus ();
  clk_rate_checker_if bus_sat ();

  clk_rate_checker #(
    .SAMPLE_PERIOD(24'd16),
    .CONFIRM_N    (3),
    .STOP_LIMIT   (32'd16)
  ) dut (
    .clk100  (clk100),
    .reset_in(reset_in),
    .bus     (bus.slave)
  );

  // Sample every cycle and switch on the first sample, so saturation is reachable quickly.
  clk_rate_checker #(
    .SAMPLE_PERIOD(24'd1),
    .CONFIRM_N    (1),
    .STOP_LIMIT   (32'd16)
  ) dut_sat (
    .clk100  (clk_fast),
    .reset_in(reset_fast),
    .bus     (bus_sat.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  // Starts just after a capture edge (or reset edge) and ends just after the next capture edge.
  task automatic sample(input logic [31:0] v, input logic clr);
    bus.value_in = v;
    tick(1);
    check("sv_after_pulse", {31'd0, bus.sample_valid}, 32'd0);
    tick(14);
    check("sv_before_capture", {31'd0, bus.sample_valid}, 32'd0);
    bus.clear_alarm = clr;
    tick(1);
    bus.clear_alarm = 1'b0;
    check("sv_pulse", {31'd0, bus.sample_valid}, 32'd1);
    check("sample_value", bus.sample_value, v);
  endtask

  task automatic expect_status(input string tag, input logic [2:0] st, input logic ok,
                               input logic al, input logic [15:0] fc);
    check({tag, "_state"}, {29'd0, bus.state}, {29'd0, st});
    check({tag, "_rate_ok"}, {31'd0, bus.rate_ok}, {31'd0, ok});
    check({tag, "_alarm"}, {31'd0, bus.alarm_sticky}, {31'd0, al});
    check({tag, "_fault_count"}, {16'd0, bus.fault_count}, {16'd0, fc});
  endtask

  initial begin
    reset_in        = 1'b1;
    reset_fast      = 1'b1;
    bus.value_in    = 32'hFFFFFFFF;
    bus.lo_limit    = 32'd1000;
    bus.hi_limit    = 32'd1100;
    bus.clear_alarm = 1'b0;
    bus_sat.value_in    = 32'hFFFFFFFF;
    bus_sat.lo_limit    = 32'd1000;
    bus_sat.hi_limit    = 32'd1100;
    bus_sat.clear_alarm = 1'b0;
    tick(3);
    expect_status("reset", 3'd0, 1'b0, 1'b0, 16'd0);
    check("reset_sample_valid", {31'd0, bus.sample_valid}, 32'd0);
    check("reset_sample_value", bus.sample_value, 32'hFFFFFFFF);
    reset_in = 1'b0;

    // No measurement yet: samples arrive every 16 cycles, state stays INIT
    sample(32'hFFFFFFFF, 1'b0);
    expect_status("invalid1", 3'd0, 1'b0, 1'b0, 16'd0);
    sample(32'hFFFFFFFF, 1'b0);
    expect_status("invalid2", 3'd0, 1'b0, 1'b0, 16'd0);

    // OK after three confirming samples
    sample(32'd1050, 1'b0);
    sample(32'd1050, 1'b0);
    expect_status("ok_pending", 3'd0, 1'b0, 1'b0, 16'd0);
    sample(32'd1050, 1'b0);
    expect_status("ok_entry", 3'd1, 1'b1, 1'b0, 16'd0);

    // Interrupted LOW run is discarded, then a full run enters LOW
    sample(32'd900, 1'b0);
    sample(32'd900, 1'b0);
    sample(32'd1050, 1'b0);
    expect_status("low_interrupted", 3'd1, 1'b1, 1'b0, 16'd0);
    sample(32'd900, 1'b0);
    sample(32'd900, 1'b0);
    expect_status("low_pending", 3'd1, 1'b1, 1'b0, 16'd0);
    sample(32'd900, 1'b0);
    expect_status("low_entry", 3'd2, 1'b0, 1'b1, 16'd1);

    // STOPPED entry with clear on the same cycle: set wins; later clear works
    sample(32'd0, 1'b0);
    sample(32'd0, 1'b0);
    sample(32'd0, 1'b1);
    expect_status("stop_entry_clear", 3'd4, 1'b0, 1'b1, 16'd2);
    sample(32'd0, 1'b1);
    expect_status("stop_cleared", 3'd4, 1'b0, 1'b0, 16'd2);

    // HIGH, then INVALID drops to INIT at once, then back to OK
    sample(32'd1200, 1'b0);
    sample(32'd1200, 1'b0);
    sample(32'd1200, 1'b0);
    expect_status("high_entry", 3'd3, 1'b0, 1'b1, 16'd3);
    sample(32'hFFFFFFFF, 1'b0);
    expect_status("invalid_init", 3'd0, 1'b0, 1'b1, 16'd3);
    sample(32'd1050, 1'b0);
    sample(32'd1050, 1'b0);
    expect_status("reok_pending", 3'd0, 1'b0, 1'b1, 16'd3);
    sample(32'd1050, 1'b0);
    expect_status("reok_entry", 3'd1, 1'b1, 1'b1, 16'd3);

    // Inclusive limits and alternating out-of-range classes
    sample(32'd1000, 1'b0);
    sample(32'd1100, 1'b0);
    sample(32'd1000, 1'b0);
    expect_status("limits_inclusive", 3'd1, 1'b1, 1'b1, 16'd3);
    sample(32'd999, 1'b0);
    sample(32'd1101, 1'b0);
    sample(32'd999, 1'b0);
    sample(32'd1101, 1'b0);
    expect_status("alternating", 3'd1, 1'b1, 1'b1, 16'd3);

    // 15 is STOPPED, 16 is merely LOW; fault-to-fault transition counts
    sample(32'd15, 1'b0);
    sample(32'd15, 1'b0);
    sample(32'd15, 1'b0);
    expect_status("stop_limit", 3'd4, 1'b0, 1'b1, 16'd4);
    sample(32'd16, 1'b0);
    sample(32'd16, 1'b0);
    sample(32'd16, 1'b0);
    expect_status("stop_to_low", 3'd2, 1'b0, 1'b1, 16'd5);

    // lo_limit > hi_limit: LOW takes priority over HIGH
    bus.lo_limit = 32'd2000;
    bus.hi_limit = 32'd1500;
    sample(32'd1800, 1'b0);
    sample(32'd1800, 1'b0);
    sample(32'd1800, 1'b0);
    expect_status("inverted_limits", 3'd2, 1'b0, 1'b1, 16'd5);
    bus.lo_limit = 32'd1000;
    bus.hi_limit = 32'd1100;

    // Reset in mid-confirmation
    sample(32'd1050, 1'b0);
    sample(32'd1050, 1'b0);
    expect_status("pre_reset", 3'd2, 1'b0, 1'b1, 16'd5);
    reset_in = 1'b1;
    tick(1);
    reset_in = 1'b0;
    expect_status("mid_reset", 3'd0, 1'b0, 1'b0, 16'd0);
    check("mid_reset_sample_valid", {31'd0, bus.sample_valid}, 32'd0);
    check("mid_reset_sample_value", bus.sample_value, 32'hFFFFFFFF);
    sample(32'd1050, 1'b0);
    expect_status("post_reset1", 3'd0, 1'b0, 1'b0, 16'd0);
    sample(32'd1050, 1'b0);
    expect_status("post_reset2", 3'd0, 1'b0, 1'b0, 16'd0);
    sample(32'd1050, 1'b0);
    expect_status("post_reset3", 3'd1, 1'b1, 1'b0, 16'd0);

    // Saturation: each fast-clock edge is one LOW/HIGH entry
    @(posedge clk_fast);
    #1;
    reset_fast = 1'b0;
    bus_sat.value_in = 32'd900;
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk_fast);
      #1;
      bus_sat.value_in = (bus_sat.value_in == 32'd900) ? 32'd1200 : 32'd900;
    end
    check("sat_fffe", {16'd0, bus_sat.fault_count}, 32'h0000FFFE);
    check("sat_state_high", {29'd0, bus_sat.state}, 32'd3);
    @(posedge clk_fast);
    #1;
    check("sat_ffff", {16'd0, bus_sat.fault_count}, 32'h0000FFFF);
    check("sat_state_low", {29'd0, bus_sat.state}, 32'd2);
    bus_sat.value_in = 32'd1200;
    @(posedge clk_fast);
    #1;
    bus_sat.value_in = 32'd900;
    @(posedge clk_fast);
    #1;
    check("sat_hold", {16'd0, bus_sat.fault_count}, 32'h0000FFFF);
    check("sat_alarm", {31'd0, bus_sat.alarm_sticky}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
